// File: rtl/audio_resamp_pkg.sv
// Shared types and constants for the linear audio resampler.
// The optional dither LFSR constants are only consumed when AUDIO_RESAMP_DITHER_EN is defined.
package audio_resamp_pkg;

    localparam int unsigned DEF_IW           = 16;
    localparam int unsigned DEF_FW           = 12;
    localparam int unsigned DEF_MCLK_RATE    = 53693175;
    localparam int unsigned DEF_DATA_CLK_IN  = 300000;
    localparam int unsigned DEF_DATA_CLK_OUT = 48000;

    typedef logic signed [DEF_IW-1:0] sample_t;
    typedef logic        [DEF_FW-1:0] mu_t;

    // round(2^fw * rate_in / mclk), computed in 64 bits to avoid overflow
    function automatic int unsigned calc_step(input int unsigned fw,
                                              input int unsigned rate_in,
                                              input int unsigned mclk);
        logic [63:0] num;
        num = (64'd1 << fw) * 64'(rate_in);
        return 32'((num + 64'(mclk / 2)) / 64'(mclk));
    endfunction

    localparam int unsigned STEP       = calc_step(DEF_FW, DEF_DATA_CLK_IN, DEF_MCLK_RATE);
    localparam int unsigned ROUND_HALF = 1 << (DEF_FW - 1);

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/audio_frac_tick_gen.sv
// Fractional rate tick generator: exactly TICK_RATE one-cycle ticks per CLK_RATE clocks.
// Reusable by any audio rate converter needing an exact-average output cadence.
module audio_frac_tick_gen #(
    parameter int unsigned TICK_RATE = 48000,
    parameter int unsigned CLK_RATE  = 53693175
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [31:0] acc;
    logic [32:0] sum;

    always_comb begin
        sum  = {1'b0, acc} + 33'(TICK_RATE);
        tick = (sum >= 33'(CLK_RATE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (tick) begin
            acc <= 32'(sum - 33'(CLK_RATE));
        end else begin
            acc <= sum[31:0];
        end
    end

endmodule

// File: rtl/audio_linear_resampler.sv
// Linear-interpolating resampler from ~DATA_CLK_IN to an exact-average DATA_CLK_OUT stream.
// Define AUDIO_RESAMP_DITHER_EN to replace the round-half term with LFSR rectangular dither.
module audio_linear_resampler
    import audio_resamp_pkg::*;
#(
    parameter int unsigned IW           = DEF_IW,
    parameter int unsigned FW           = DEF_FW,
    parameter int unsigned MCLK_RATE    = DEF_MCLK_RATE,
    parameter int unsigned DATA_CLK_IN  = DEF_DATA_CLK_IN,
    parameter int unsigned DATA_CLK_OUT = DEF_DATA_CLK_OUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] data_in,
    output logic signed [IW-1:0] data_out,
    output logic                 out_valid,
    output logic                 stale
);

    localparam int unsigned PH_STEP = calc_step(FW, DATA_CLK_IN, MCLK_RATE);
    localparam int unsigned PW      = IW + FW + 2;
    localparam logic [FW:0]   PH_INC  = PH_STEP[FW:0];
    localparam logic [FW:0]   PH_MAX  = {1'b0, {FW{1'b1}}};
    localparam logic [FW-1:0] ROUND_C = {1'b1, {(FW-1){1'b0}}};

    logic                 tick;
    logic [FW:0]          ph, ph_sum;
    logic                 ph_sat;
    logic signed [IW-1:0] x_prev, x_cur;
    logic                 s1_valid;
    logic signed [IW:0]   s1_d;
    logic signed [IW-1:0] s1_xp;
    logic [FW-1:0]        s1_mu;
    logic [FW-1:0]        rnd_term;
    logic signed [PW-1:0] d_ext, mu_ext, p, p_rnd;
    logic signed [IW-1:0] y;

    audio_frac_tick_gen #(
        .TICK_RATE (DATA_CLK_OUT),
        .CLK_RATE  (MCLK_RATE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        ph_sum = ph + PH_INC;
        ph_sat = (ph_sum >= PH_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph     <= '0;
            x_prev <= '0;
            x_cur  <= '0;
            stale  <= 1'b0;
        end else if (in_valid) begin
            ph     <= '0;
            x_prev <= x_cur;
            x_cur  <= data_in;
            stale  <= 1'b0;
        end else begin
            ph <= ph_sat ? PH_MAX : ph_sum;
            if (ph_sat) begin
                stale <= 1'b1;
            end
        end
    end

    // S1 samples the register values, so a coincident in_valid shift is not seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_xp    <= '0;
            s1_mu    <= '0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1_d  <= {x_cur[IW-1], x_cur} - {x_prev[IW-1], x_prev};
                s1_xp <= x_prev;
                s1_mu <= ph[FW-1:0];
            end
        end
    end

`ifdef AUDIO_RESAMP_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
        end
    end

    assign rnd_term = lfsr[15 -: FW];
`else
    assign rnd_term = ROUND_C;
`endif

    always_comb begin
        d_ext  = PW'(s1_d);
        mu_ext = PW'({1'b0, s1_mu});
        p      = d_ext * mu_ext;
        p_rnd  = p + $signed(PW'(rnd_term));
        y      = IW'(PW'(s1_xp) + (p_rnd >>> FW));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= y;
            end
        end
    end

endmodule
